pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RISC-V pipeline, sitting beside the Control_Unit decode path. Each cycle it decides:
- the pipeline-register enables and flushes, based on load-use hazards, taken branches and multi-cycle data-memory accesses;
- the EX-stage operand forwarding selects.

A small FSM with a watchdog counter sequences data-memory wait states. An optional performance-counter bank is compiled in by macro.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/forwarding_unit.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

  // Data-memory sequencing states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // A later-stage writer supplies this source; x0 is hard-wired and never forwarded
  function automatic logic fwd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX-stage operand forwarding selects, EX/MEM over MEM/WB
module forwarding_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  // The youngest producer wins: EX/MEM is checked before MEM/WB
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (fwd_hit(i_mem_reg_write, i_mem_rd, i_ex_rs1))     o_fwd_a = FWD_MEM;
    else if (fwd_hit(i_wb_reg_write, i_wb_rd, i_ex_rs1))  o_fwd_a = FWD_WB;
    if (fwd_hit(i_mem_reg_write, i_mem_rd, i_ex_rs2))     o_fwd_b = FWD_MEM;
    else if (fwd_hit(i_wb_reg_write, i_wb_rd, i_ex_rs2))  o_fwd_b = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush priority, dmem wait FSM with watchdog; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  hz_state_e       r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_err;

  logic       w_timeout;
  logic       w_freeze;
  logic       w_load_use;
  logic       w_branch_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Timeout releases the pipeline exactly like a late dmem_ready would
  assign w_timeout  = (r_state == MEM_WAIT) && !dmem_ready && (r_wait_cnt == WC_LAST);
  assign w_freeze   = ((r_state == RUN) && mem_req && !dmem_ready) ||
                      ((r_state == MEM_WAIT) && !dmem_ready && !w_timeout);
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign w_branch_flush = !w_freeze && ex_branch_taken;

  forwarding_unit u_fwd (
    .i_ex_rs1        (ex_rs1),
    .i_ex_rs2        (ex_rs2),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_fwd_a         (w_fwd_a),
    .o_fwd_b         (w_fwd_b)
  );

  assign fwd_a   = rst_n ? w_fwd_a : FWD_RF;
  assign fwd_b   = rst_n ? w_fwd_b : FWD_RF;
  assign mem_err = r_mem_err;

  // Enable/flush priority: reset, freeze, branch, load-use, run
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n || w_freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if (!rst_n) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Data-memory wait FSM with watchdog; mem_err pulses the cycle after a timeout release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (mem_req && !dmem_ready) r_state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counters of stalled and branch-flushed cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)         stall_cnt <= stall_cnt + 1'b1;
      if (w_branch_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write, mem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;
  exp_t sb[$];

  wire [11:0] obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_err};

  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_NO  = 5'b00000;
  localparam logic [4:0] EN_LU  = 5'b00111;

  function automatic logic [11:0] ev(input logic [4:0] en, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic err);
    return {en, fl, fa, fb, err};
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  // Push the expectation for the current cycle, compare at the falling edge, advance one cycle
  task automatic step(input string tag, input logic [11:0] exp);
    exp_t item;
    item.tag = tag;
    item.exp = exp;
    sb.push_back(item);
    @(negedge clk);
    item = sb.pop_front();
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", item.tag, obs, item.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    clear_inputs();
    ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1;
    @(posedge clk); #1;
    step("reset_outputs", ev(EN_NO, 2'b11, FWD_RF, FWD_RF, 1'b0));
    chk("reset_state", 32'(dut.r_state), 32'(RUN));
    rst_n = 1'b1;
    clear_inputs();
    step("idle", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    step("load_use_rs1", ev(EN_LU, 2'b01, FWD_RF, FWD_RF, 1'b0));
    id_rs1 = 0; id_rs2 = 5;
    step("load_use_rs2", ev(EN_LU, 2'b01, FWD_RF, FWD_RF, 1'b0));
    ex_rd = 0; id_rs2 = 0;
    step("load_x0_no_stall", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    clear_inputs();
    ex_branch_taken = 1;
    step("branch", ev(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0));
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    step("branch_over_load_use", ev(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0));

    clear_inputs();
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7;
    step("fwd_mem_priority", ev(EN_ALL, 2'b00, FWD_MEM, FWD_RF, 1'b0));
    mem_reg_write = 0;
    step("fwd_wb", ev(EN_ALL, 2'b00, FWD_WB, FWD_RF, 1'b0));
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
    step("fwd_x0", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));
    mem_rd = 9; wb_rd = 9; ex_rs1 = 9; ex_rs2 = 9; mem_reg_write = 0;
    ex_mem_read = 1; ex_rd = 3; id_rs2 = 3;
    step("fwd_b_during_stall", ev(EN_LU, 2'b01, FWD_WB, FWD_WB, 1'b0));

    clear_inputs();
    mem_req = 1; dmem_ready = 1;
    step("single_cycle_access", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));
    chk("single_cycle_state", 32'(dut.r_state), 32'(RUN));

    dmem_ready = 0;
    step("wait_1", ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    ex_branch_taken = 1;
    step("wait_2_branch_held", ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    ex_branch_taken = 0;
    step("wait_3", ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    dmem_ready = 1;
    step("wait_release", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));
    mem_req = 0; dmem_ready = 0;
    chk("wait_back_to_run", 32'(dut.r_state), 32'(RUN));
    step("wait_no_err", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    mem_req = 1;
    for (int i = 0; i < TO; i++) step($sformatf("timeout_frozen_%0d", i), ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    step("timeout_release", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));
    mem_req = 0;
    step("timeout_mem_err", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b1));
    step("timeout_err_pulse_end", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    mem_req = 1;
    step("midwait_frozen_0", ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    step("midwait_frozen_1", ev(EN_NO, 2'b00, FWD_RF, FWD_RF, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_state", 32'(dut.r_state), 32'(RUN));
    chk("midwait_reset_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
    step("midwait_reset_outputs", ev(EN_NO, 2'b11, FWD_RF, FWD_RF, 1'b0));
    rst_n = 1'b1;
    mem_req = 0;
    step("after_reset_idle", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    step("cnt_load_use", ev(EN_LU, 2'b01, FWD_RF, FWD_RF, 1'b0));
    clear_inputs();
    ex_branch_taken = 1;
    step("cnt_branch", ev(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0));
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd1);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    step("final_idle", ev(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

endmodule
